// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Brief    : Shared encodings for the multiply/divide unit (operation codes,
//            controller state) used by the MDU, decoder and hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // Operation selector driven by the decoder alongside start
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  // Controller state: idle (accepting) or running a timed operation
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for the operations that occupy the unit for a busy window
  function automatic logic is_timed_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// Module   : md_arith
// Brief    : Combinational product / quotient / remainder datapath including
//            the divide-by-zero and signed-overflow result rules. Kept apart
//            from the timing shell so it can be swapped for an iterative core.
// Revision : 1.0 - initial release
// ============================================================================
module md_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e             i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  localparam logic [WIDTH-1:0] c_INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ALL1    = {WIDTH{1'b1}};

  logic               w_mul_signed;
  logic               w_div_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_b_safe;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic               w_b_zero;
  logic               w_overflow;

  assign w_mul_signed = (i_op == MD_MULT);
  assign w_div_signed = (i_op == MD_DIV);
  assign w_a_neg      = i_a[WIDTH-1];
  assign w_b_neg      = i_b[WIDTH-1];

  // A 2W-bit modular multiply of the correctly extended operands yields the
  // exact signed or unsigned product, so one multiplier serves both forms.
  assign w_a_ext = w_mul_signed ? {{WIDTH{w_a_neg}}, i_a} : {{WIDTH{1'b0}}, i_a};
  assign w_b_ext = w_mul_signed ? {{WIDTH{w_b_neg}}, i_b} : {{WIDTH{1'b0}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide works on magnitudes; signs are restored afterwards so the
  // quotient truncates toward zero and the remainder follows the dividend.
  assign w_a_mag  = (w_div_signed && w_a_neg) ? (~i_a + c_ONE) : i_a;
  assign w_b_mag  = (w_div_signed && w_b_neg) ? (~i_b + c_ONE) : i_b;
  assign w_b_zero = (i_b == '0);
  assign w_b_safe = w_b_zero ? c_ONE : w_b_mag;
  assign w_q_mag  = w_a_mag / w_b_safe;
  assign w_r_mag  = w_a_mag % w_b_safe;

  assign w_overflow = w_div_signed && (i_a == c_INT_MIN) && (i_b == c_ALL1);

  // Select the HI/LO pair for the requested operation
  always_comb begin
    o_hi = '0;
    o_lo = '0;
    case (i_op)
      MD_MULT, MD_MULTU: begin
        {o_hi, o_lo} = w_prod;
      end
      MD_DIV, MD_DIVU: begin
        if (w_b_zero) begin
          o_lo = c_ALL1;
          o_hi = i_a;
        end else if (w_overflow) begin
          o_lo = c_INT_MIN;
          o_hi = '0;
        end else begin
          o_lo = (w_div_signed && (w_a_neg ^ w_b_neg)) ? (~w_q_mag + c_ONE) : w_q_mag;
          o_hi = (w_div_signed && w_a_neg)             ? (~w_r_mag + c_ONE) : w_r_mag;
        end
      end
      default: begin
        o_hi = '0;
        o_lo = '0;
      end
    endcase
  end

endmodule : md_arith
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Multi-cycle multiply/divide unit with HI/LO registers. Timed ops
//            hold busy for a fixed window then commit; MTHI/MTLO write
//            directly; cancel aborts an in-flight op leaving HI/LO intact.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] c_MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  md_op_e           w_op;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_accept;

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic [WIDTH-1:0] r_pend_hi;
  logic [WIDTH-1:0] r_pend_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  assign w_op     = md_op_e'(op);
  assign w_accept = start && !cancel && (r_state == ST_IDLE);

  md_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .i_op (w_op),
    .i_a  (a),
    .i_b  (b),
    .o_hi (w_res_hi),
    .o_lo (w_res_lo)
  );

  // Controller: capture result at accept, count the busy window, commit or abort
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (is_timed_op(w_op)) begin
              r_pend_hi <= w_res_hi;
              r_pend_lo <= w_res_lo;
              r_count   <= ((w_op == MD_MULT) || (w_op == MD_MULTU)) ? c_MULT_CNT : c_DIV_CNT;
              r_busy    <= 1'b1;
              r_state   <= ST_RUN;
            end else if (w_op == MD_MTHI) begin
              r_hi <= a;
            end else if (w_op == MD_MTLO) begin
              r_lo <= a;
            end
          end
        end
        ST_RUN: begin
          // cancel takes priority even on the completion edge
          if (cancel) begin
            r_count <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_count == c_CNT_ONE) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_count <= r_count - c_CNT_ONE;
          end
        end
        default: begin
          r_count <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule : mul_div_unit
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Scoreboard bench for mul_div_unit: default-timing instance plus a
//            short-timing instance (MULT_CYCLES=1, DIV_CYCLES=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
  import mdu_pkg::*;

  localparam logic [31:0] c_A5 = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic        cancel = 1'b0;
  logic        cancel_s = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, busy_s;
  logic [31:0] hi, lo, hi_s, lo_s;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  mul_div_unit #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .op(op), .a(a), .b(b),
    .cancel(cancel_s), .busy(busy_s), .hi(hi_s), .lo(lo_s)
  );

  // The hazard unit must never present a request while the unit is busy
  a_no_start_busy: assert property (@(posedge clk) disable iff (!reset) !(start && busy))
    else $error("start asserted while busy");
  a_no_start_busy_s: assert property (@(posedge clk) disable iff (!reset) !(start_s && busy_s))
    else $error("start asserted while busy (short instance)");

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one op, measure the busy window, then compare against the scoreboard
  task automatic run_op(input bit sel, input md_op_e o, input logic [31:0] ia, input logic [31:0] ib,
                        input int exp_cyc, input logic [31:0] eh, input logic [31:0] el,
                        input string tag);
    int n;
    logic [63:0] exp;
    sb_q.push_back({eh, el});
    @(negedge clk);
    op = o; a = ia; b = ib;
    if (sel) start_s = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_s = 1'b0;
    n = 0;
    while ((sel ? busy_s : busy) && n < 64) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    exp = sb_q.pop_front();
    chk({tag, "_hi"}, 64'(sel ? hi_s : hi), 64'(exp[63:32]));
    chk({tag, "_lo"}, 64'(sel ? lo_s : lo), 64'(exp[31:0]));
  endtask

  // MULTU 3*4 aborted during busy cycle cyc; HI/LO must keep their old values
  task automatic run_cancel(input int cyc, input string tag);
    logic [63:0] exp;
    sb_q.push_back({c_A5, c_A5});
    @(negedge clk);
    op = MD_MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= cyc; i++) begin
      chk({tag, "_busy_before"}, 64'(busy), 64'd1);
      if (i == cyc) cancel = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    cancel = 1'b0;
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    exp = sb_q.pop_front();
    chk({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
    repeat (7) @(negedge clk);
    chk({tag, "_lo_later"}, 64'(lo), 64'(exp[31:0]));
  endtask

  initial begin
    logic [31:0] ra, rb;
    longint      sp;
    logic [63:0] up;

    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(0, MD_MULTU, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, "multu_max");
    run_op(0, MD_MULT,  32'hFFFFFFFD, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg");
    run_op(0, MD_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
    run_op(0, MD_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_negb");
    run_op(0, MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf");
    run_op(0, MD_DIVU,  32'hFFFFFFFF, 32'h10, 10, 32'h0000000F, 32'h0FFFFFFF, "divu_big");
    run_op(0, MD_DIVU,  32'd5, 32'd0, 10, 32'h00000005, 32'hFFFFFFFF, "divu_zero");
    run_op(0, MD_DIV,   32'hFFFFFFFB, 32'd0, 10, 32'hFFFFFFFB, 32'hFFFFFFFF, "div_zero");
    run_op(0, MD_MTLO,  32'h1234, 32'd0, 0, 32'hFFFFFFFB, 32'h00001234, "mtlo");

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom;
      up = {32'b0, ra} * {32'b0, rb};
      run_op(0, MD_MULTU, ra, rb, 5, up[63:32], up[31:0], "multu_rnd");
      sp = longint'($signed(ra)) * longint'($signed(rb));
      run_op(0, MD_MULT, ra, rb, 5, sp[63:32], sp[31:0], "mult_rnd");
      rb = ($urandom % 1000) + 1;
      run_op(0, MD_DIVU, ra, rb, 10, ra % rb, ra / rb, "divu_rnd");
    end

    // Cancel scenarios from a known HI/LO value
    run_op(0, MD_MTHI, c_A5, 32'd0, 0, c_A5, lo, "mthi");
    run_op(0, MD_MTLO, c_A5, 32'd0, 0, c_A5, c_A5, "mtlo_a5");
    run_cancel(3, "cancel_mid");
    run_cancel(5, "cancel_last");

    // start together with cancel in IDLE is dropped
    @(negedge clk);
    op = MD_MULTU; a = 32'd3; b = 32'd4; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("idle_cancel_busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    chk("idle_cancel_lo", 64'(lo), 64'(c_A5));

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_hi", 64'(hi), 64'd0);
    chk("async_rst_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(0, MD_MULTU, 32'd2, 32'd3, 5, 32'd0, 32'd6, "multu_after_rst");

    // Short-timing instance: 1-cycle multiply, 3-cycle divide
    run_op(1, MD_MULT, 32'd3, 32'hFFFFFFFB, 1, 32'hFFFFFFFF, 32'hFFFFFFF1, "short_mult");
    run_op(1, MD_DIV,  32'd9, 32'd2, 3, 32'd1, 32'd4, "short_div");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mul_div_unit
`default_nettype wire
